edecode_seq: RTL



---
 rtl/edecode_pkg.sv | 29 ++
 rtl/edecode_onehot.sv | 17 +
 rtl/edecode_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/edecode_pkg.sv
// Shared definitions for the edecode_seq decoder: mode encodings, FSM state
// encodings and the binary-to-one-hot helper.
// Optional build macro used by the top level: EDECODE_SCAN_DIR_EN.
package edecode_pkg;

    // Operating modes presented on the mode input
    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    // FSM states; the plain constants below carry the same encoding for
    // code that keeps the state in an untyped logic vector
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_SCAN  = 2'd2
    } state_e;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;

    // Binary index (up to 6 bits) to one-hot; callers keep the low 2**SEL_W bits
    function automatic logic [63:0] onehot(input logic [5:0] s);
        onehot = 64'd1 << s;
    endfunction

endpackage

// File: rtl/edecode_onehot.sv
// Pure combinational binary-to-one-hot decoder with enable. Output is all
// zero when en_i is low.
module edecode_onehot
    import edecode_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    en_i,
    output logic [(1<<SEL_W)-1:0]   y_o
);

    localparam int N = 1 << SEL_W;

    assign y_o = en_i ? N'(onehot(6'(sel_i))) : '0;

endmodule

// File: rtl/edecode_seq.sv
// Registered parametrised one-hot decoder with STATIC, PULSE and SCAN modes.
// Build macro EDECODE_SCAN_DIR_EN adds a dir input selecting scan direction
// (sampled when a scan is accepted); without it scans always count upward.
module edecode_seq
    import edecode_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 4,
    parameter int SCAN_DIV  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
`ifdef EDECODE_SCAN_DIR_EN
    input  logic                    dir,
`endif
    output logic                    in_ready,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic                    busy,
    output logic [SEL_W-1:0]        active_idx
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = $clog2(PULSE_LEN + 1);
    localparam int DIV_W = $clog2(SCAN_DIV + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] idx_step;
    logic [N-1:0]     y_q;
    logic             busy_q;
    logic [SEL_W-1:0] aidx_q;

    logic             dec_en;
    logic [SEL_W-1:0] dec_sel;
    logic [N-1:0]     dec_y;

`ifdef EDECODE_SCAN_DIR_EN
    logic             dir_q, dir_d;

    // Next scan position honours the direction latched at acceptance
    assign idx_step = dir_q ? (idx_q - SEL_W'(1)) : (idx_q + SEL_W'(1));
`else
    // Next scan position always counts upward, wrapping naturally
    assign idx_step = idx_q + SEL_W'(1);
`endif

    // A start is only possible from IDLE while enabled in PULSE or SCAN mode
    assign in_ready = (state_q == S_IDLE) && en &&
                      ((mode == MODE_PULSE) || (mode == MODE_SCAN));

    // Next-state, counter and decoder-input selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
`ifdef EDECODE_SCAN_DIR_EN
        dir_d   = dir_q;
`endif
        dec_en  = 1'b0;
        dec_sel = idx_q;

        if (!en) begin
            // Disable aborts everything on the next edge
            state_d = S_IDLE;
            cnt_d   = '0;
            div_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    case (mode)
                        MODE_STATIC: begin
                            idx_d   = sel;
                            dec_sel = sel;
                            dec_en  = 1'b1;
                        end
                        MODE_PULSE: begin
                            if (in_valid) begin
                                idx_d   = sel;
                                dec_sel = sel;
                                dec_en  = 1'b1;
                                cnt_d   = CNT_LOAD;
                                state_d = S_PULSE;
                            end
                        end
                        MODE_SCAN: begin
                            if (in_valid) begin
                                idx_d   = sel;
                                dec_sel = sel;
                                dec_en  = 1'b1;
                                div_d   = DIV_LOAD;
`ifdef EDECODE_SCAN_DIR_EN
                                dir_d   = dir;
`endif
                                state_d = S_SCAN;
                            end
                        end
                        MODE_RSVD: begin
                            dec_en = 1'b0;
                        end
                    endcase
                end
                S_PULSE: begin
                    // Hold the strobe until the remaining-cycle count runs out
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        dec_en = 1'b1;
                    end
                end
                S_SCAN: begin
                    dec_en = 1'b1;
                    if (div_q == '0) begin
                        idx_d = idx_step;
                        div_d = DIV_LOAD;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                    dec_sel = idx_d;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    edecode_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel_i (dec_sel),
        .en_i  (dec_en),
        .y_o   (dec_y)
    );

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            aidx_q  <= '0;
`ifdef EDECODE_SCAN_DIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            y_q     <= dec_y;
            busy_q  <= (state_d != S_IDLE);
            aidx_q  <= dec_en ? dec_sel : '0;
`ifdef EDECODE_SCAN_DIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign y          = y_q;
    assign busy       = busy_q;
    assign active_idx = aidx_q;

endmodule
